// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered clock, 11-bit frame decode, FIFO of scan codes, sticky error flags.
// Latency: ready, level and scan_code update one clk edge after the cycle in which the stop bit is sampled.
// Backpressure: none toward the device; a good frame arriving while full is dropped and flagged (optional frame timeout: PS2_RX_TIMEOUT_EN).
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2     = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ps2_clk,
    input  logic                  i_ps2_data,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [7:0]            o_scan_code,
    output logic                  o_ready,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_parity_err,
    output logic                  o_frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   w_clk_s;
    logic                   w_dat_s;

    logic [3:0]             r_flt_cnt;
    logic                   r_clk_flt;
    logic                   r_clk_flt_prev;
    logic                   w_fall;

    logic [3:0]             r_bit_cnt;
    logic [9:0]             r_frame;
    logic                   w_frame_end;
    logic                   w_bad_frame;
    logic                   w_bad_par;
    logic                   w_good;
    logic                   w_timeout;

    logic [7:0]             r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    logic                   r_overflow;
    logic                   r_parity_err;
    logic                   r_frame_err;

    // Synchronisers idle high so reset never produces a spurious falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

    // Filtered clock follows the synced pin only after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flt_cnt      <= '0;
            r_clk_flt      <= 1'b1;
            r_clk_flt_prev <= 1'b1;
        end else begin
            r_clk_flt_prev <= r_clk_flt;
            if (w_clk_s == r_clk_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == 4'(FILTER_LEN - 1)) begin
                r_flt_cnt <= '0;
                r_clk_flt <= w_clk_s;
            end else begin
                r_flt_cnt <= r_flt_cnt + 4'd1;
            end
        end
    end

    assign w_fall = r_clk_flt_prev & ~r_clk_flt;

    // r_frame holds bits 0..9 once the stop bit arrives: [0]=start, [8:1]=data, [9]=parity.
    assign w_frame_end = w_fall && (r_bit_cnt == 4'd10);
    assign w_bad_frame = r_frame[0] | ~w_dat_s;
    assign w_bad_par   = ~(^r_frame[9:1]);
    assign w_good      = w_frame_end && !w_bad_frame && !w_bad_par;

    assign w_full = (r_level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign w_pop  = i_rd_en && (r_level != '0);
    assign w_push = w_good && (!w_full || w_pop);
    assign w_drop = w_good && w_full && !w_pop;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_idle;

    assign w_timeout = (r_bit_cnt != 4'd0) && !w_fall &&
                       (r_idle == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (w_fall || (r_bit_cnt == 4'd0) || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_frame   <= '0;
        end else if (w_timeout) begin
            r_bit_cnt <= '0;
        end else if (w_fall) begin
            r_frame   <= {w_dat_s, r_frame[9:1]};
            r_bit_cnt <= (r_bit_cnt == 4'd10) ? 4'd0 : r_bit_cnt + 4'd1;
        end
    end

    // A new error event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_overflow   <= (r_overflow & ~i_clr_err) | w_drop;
            r_parity_err <= (r_parity_err & ~i_clr_err) |
                            (w_frame_end & ~w_bad_frame & w_bad_par);
            r_frame_err  <= (r_frame_err & ~i_clr_err) |
                            (w_frame_end & w_bad_frame) | w_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_frame[8:1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_scan_code  = r_mem[r_rd_ptr];
    assign o_ready      = (r_level != '0);
    assign o_level      = r_level;
    assign o_overflow   = r_overflow;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames driven bit by bit, accepted bytes tracked in a scoreboard queue.
module tb_ps2_rx_fifo;

    localparam int S  = 2;
    localparam int F  = 4;
    localparam int TO = 200;
    localparam int DL = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ps2_clk;
    logic          ps2_data;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    scan_code;
    logic          ready;
    logic [DL:0]   level;
    logic          overflow;
    logic          parity_err;
    logic          frame_err;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    sb [$];

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH_LOG2    (DL),
        .SYNC_STAGES   (S),
        .FILTER_LEN    (F),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .i_rd_en     (rd_en),
        .i_clr_err   (clr_err),
        .o_scan_code (scan_code),
        .o_ready     (ready),
        .o_level     (level),
        .o_overflow  (overflow),
        .o_parity_err(parity_err),
        .o_frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the first nbits of a frame; with pop_at_end, rd_en is raised in the cycle the stop bit is sampled.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                              input logic pop_at_end, input int nbits);
        logic [10:0] fr;
        fr = {stop_bit, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (15) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_at_end && i == 10) begin
                repeat (S + F) @(posedge clk);
                #1;
                chk("head_at_collision", {24'd0, scan_code}, {24'd0, sb[0]});
                void'(sb.pop_front());
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
            end
            repeat (20) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_data"}, {24'd0, scan_code}, {24'd0, sb[0]});
        void'(sb.pop_front());
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk({tag, "_level"}, {28'd0, level}, sb.size());
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic push_model(input logic [7:0] d);
        if (sb.size() < (1 << DL)) sb.push_back(d);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_flags", {29'd0, overflow, parity_err, frame_err}, 32'd0);

        // Three-frame sequence, drained in order.
        push_model(8'h1C); send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        chk("t1_level1", {28'd0, level}, 32'd1);
        push_model(8'hF0); send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 11);
        chk("t1_level2", {28'd0, level}, 32'd2);
        push_model(8'h1C); send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        chk("t1_level3", {28'd0, level}, 32'd3);
        pop_chk("t1_pop0");
        pop_chk("t1_pop1");
        pop_chk("t1_pop2");
        chk("t1_ready_empty", {31'd0, ready}, 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("t1_pop_empty_level", {28'd0, level}, 32'd0);

        // Overflow: one frame beyond depth is dropped.
        for (int i = 1; i <= (1 << DL) + 1; i++) begin
            push_model(8'(i));
            send_frame(8'(i), 1'b0, 1'b1, 1'b0, 11);
        end
        chk("t2_level_full", {28'd0, level}, 32'd8);
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < (1 << DL); i++) pop_chk("t2_pop");
        chk("t2_ready_empty", {31'd0, ready}, 32'd0);
        pulse_clr();
        chk("t2_overflow_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO with a pop in the stop-bit cycle: push accepted.
        for (int i = 0; i < (1 << DL); i++) begin
            push_model(8'h20 + 8'(i));
            send_frame(8'h20 + 8'(i), 1'b0, 1'b1, 1'b0, 11);
        end
        chk("t3_level_full", {28'd0, level}, 32'd8);
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 11);
        chk("t3_level_kept", {28'd0, level}, 32'd8);
        chk("t3_no_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < (1 << DL); i++) pop_chk("t3_pop");

        // Parity and framing errors, then clear.
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 11);
        chk("t4_parity_err", {31'd0, parity_err}, 32'd1);
        chk("t4_frame_err_clean", {31'd0, frame_err}, 32'd0);
        chk("t4_level0", {28'd0, level}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11);
        chk("t4_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t4_level0b", {28'd0, level}, 32'd0);
        pulse_clr();
        chk("t4_flags_clr", {29'd0, overflow, parity_err, frame_err}, 32'd0);

        // Glitch shorter than the filter must not be counted as a bit.
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (F - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        push_model(8'h1C); send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        chk("t5_level", {28'd0, level}, 32'd1);
        chk("t5_flags", {29'd0, overflow, parity_err, frame_err}, 32'd0);
        pop_chk("t5_pop");

`ifdef PS2_RX_TIMEOUT_EN
        // Abandoned partial frame aborts after the idle limit.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 5);
        repeat (TO + S + F + 10) @(negedge clk);
        chk("t6_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t6_level0", {28'd0, level}, 32'd0);
        pulse_clr();
        push_model(8'h1C); send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        chk("t6_level", {28'd0, level}, 32'd1);
        chk("t6_flags", {29'd0, overflow, parity_err, frame_err}, 32'd0);
        pop_chk("t6_pop");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
